// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// A single operation is in flight: IDLE grants, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_opcode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             id;
  } op_t;

  state_t           state_q;
  op_t              cap_q;
  op_t              sel_d;
  logic             last_grant_q;
  logic             gnt_vld;
  logic             gnt_id;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [7:0]       op_count_q;

  // Ready is also masked by reset so nothing looks accepted while reset is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE && reset) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_d = gnt_id ? op_t'{req1_a, req1_b, req1_opcode, 1'b1}
                   : op_t'{req0_a, req0_b, req0_opcode, 1'b0};
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      op_count_q   <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: if (gnt_vld) begin
          cap_q        <= sel_d;
          last_grant_q <= gnt_id;
          state_q      <= EXEC;
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_id_q     <= cap_q.id;
          state_q      <= RESP;
        end
        RESP: if (rsp_ready) begin
          op_count_q <= op_count_q + 8'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = (state_q == EXEC) ? cap_q.a  : '0;
  assign alu_b      = (state_q == EXEC) ? cap_q.b  : '0;
  assign alu_opcode = (state_q == EXEC) ? cap_q.op : 2'b00;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU closes the loop on alu_* / alu_result.
module tb_alu_arbiter;
  logic       clk, reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_opcode, req1_opcode, alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result, rsp_result, op_count;
  logic       rsp_valid, rsp_ready, rsp_id;
  int total, bad;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .op_count(op_count)
  );

  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_opcode = 2'b01;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_opcode = 2'b10;
    rsp_ready = 1'b1;
    cyc(); cyc();
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_req0_ready got %b want 0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_req1_ready got %b want 0", req1_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL rst_rsp_id got %b want 0", rsp_id); end
    total++; if (rsp_result !== 8'h00) begin bad++; $display("FAIL rst_rsp_result got %h want 00", rsp_result); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rst_op_count got %0d want 0", op_count); end
    total++; if ({alu_a, alu_b, alu_opcode} !== 18'd0) begin bad++; $display("FAIL rst_alu got %h/%h/%b want 0", alu_a, alu_b, alu_opcode); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20; req0_opcode = 2'b00; rsp_ready = 1'b1;
    #2;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_grant got %b%b want 10", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; #1;
    total++; if ({alu_a, alu_b, alu_opcode} !== {8'd10, 8'd20, 2'b00}) begin bad++; $display("FAIL single_alu got %h/%h/%b want 0a/14/00", alu_a, alu_b, alu_opcode); end
    total++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin bad++; $display("FAIL single_exec got v=%b r=%b want 0 0", rsp_valid, req0_ready); end
    cyc();
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'd30 || rsp_id !== 1'b0) begin bad++; $display("FAIL single_rsp got v=%b r=%h id=%b want 1 1e 0", rsp_valid, rsp_result, rsp_id); end
    total++; if (alu_a !== 8'h00) begin bad++; $display("FAIL single_alu_resp got %h want 00", alu_a); end
    cyc();
    total++; if (rsp_valid !== 1'b0 || op_count !== 8'd1) begin bad++; $display("FAIL single_done got v=%b cnt=%0d want 0 1", rsp_valid, op_count); end
  endtask

  task automatic test_tie();
    pulse_reset();
    cyc();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20; req0_opcode = 2'b01;
    req1_valid = 1'b1; req1_a = 8'd12; req1_b = 8'd10; req1_opcode = 2'b10;
    rsp_ready = 1'b1;
    #2;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL tie1_grant got %b%b want 10", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_exec_ready got %b want 0", req1_ready); end
    cyc();
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'hF6 || rsp_id !== 1'b0) begin bad++; $display("FAIL tie_rsp1 got v=%b r=%h id=%b want 1 f6 0", rsp_valid, rsp_result, rsp_id); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_resp_ready got %b want 0", req1_ready); end
    cyc();
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL tie2_grant got %b%b want 01", req0_ready, req1_ready); end
    cyc(); req1_valid = 1'b0;
    cyc();
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h08 || rsp_id !== 1'b1) begin bad++; $display("FAIL tie_rsp2 got v=%b r=%h id=%b want 1 08 1", rsp_valid, rsp_result, rsp_id); end
    cyc();
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_opcode = 2'b00;
    req1_valid = 1'b1;
    #2;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL tie3_grant got %b%b want 10", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    total++; if (rsp_result !== 8'd3 || rsp_id !== 1'b0) begin bad++; $display("FAIL tie_rsp3 got r=%h id=%b want 03 0", rsp_result, rsp_id); end
    cyc();
    total++; if (op_count !== 8'd3) begin bad++; $display("FAIL tie_count got %0d want 3", op_count); end
  endtask

  task automatic test_wrap();
    req1_valid = 1'b1; req1_a = 8'd100; req1_b = 8'd100; req1_opcode = 2'b00; rsp_ready = 1'b1;
    cyc(); req1_valid = 1'b0; #1;
    total++; if (alu_a !== 8'd100 || alu_opcode !== 2'b00) begin bad++; $display("FAIL wrap_alu got %h/%b want 64/00", alu_a, alu_opcode); end
    cyc();
    total++; if (rsp_result !== 8'hC8 || rsp_id !== 1'b1) begin bad++; $display("FAIL wrap_rsp got r=%h id=%b want c8 1", rsp_result, rsp_id); end
    cyc();
    total++; if (op_count !== 8'd4) begin bad++; $display("FAIL wrap_count got %0d want 4", op_count); end
  endtask

  task automatic test_stall();
    req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h0F; req0_opcode = 2'b11; rsp_ready = 1'b0;
    cyc(); cyc();
    req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h01; req1_opcode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h5F || rsp_id !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got v=%b r=%h id=%b want 1 5f 0", i, rsp_valid, rsp_result, rsp_id); end
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || op_count !== 8'd4) begin bad++; $display("FAIL stall_ready[%0d] got %b%b cnt=%0d want 00 4", i, req0_ready, req1_ready, op_count); end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || op_count !== 8'd5) begin bad++; $display("FAIL stall_release got v=%b cnt=%0d want 0 5", rsp_valid, op_count); end
    cyc();
    total++; if (alu_a !== 8'h00 || rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_dropped got alu=%h v=%b want 00 0", alu_a, rsp_valid); end
  endtask

  task automatic test_reset_exec();
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9; req0_opcode = 2'b00; rsp_ready = 1'b1;
    cyc(); req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++; if ({alu_a, alu_b, alu_opcode} !== 18'd0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rexec_outputs got %h/%h/%b v=%b want 0", alu_a, alu_b, alu_opcode, rsp_valid); end
    total++; if (op_count !== 8'd0 || rsp_result !== 8'h00 || rsp_id !== 1'b0) begin bad++; $display("FAIL rexec_regs got cnt=%0d r=%h id=%b want 0", op_count, rsp_result, rsp_id); end
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rexec_norsp[%0d] got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_b = 8'd1; req0_opcode = 2'b00;
    for (int i = 0; i < 256; i++) begin
      req0_a = 8'(i);
      cyc(); cyc();
      if (rsp_valid === 1'b1 && rsp_result === 8'(i + 1)) seen++;
      cyc();
      if (i == 254) begin
        total++; if (op_count !== 8'd255) begin bad++; $display("FAIL b2b_255 got %0d want 255", op_count); end
      end
    end
    req0_valid = 1'b0;
    total++; if (seen != 256) begin bad++; $display("FAIL b2b_rsps got %0d want 256", seen); end
    total++; if (op_count !== 8'd0) begin bad++; $display("FAIL b2b_wrap got %0d want 0", op_count); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_opcode = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_opcode = '0;
    test_reset();
    test_single();
    test_tie();
    test_wrap();
    test_stall();
    test_reset_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
